// File: rtl/int_sched_if.sv
// Service handshake bundle between int_sched, int_ctrl and the host register block.
// Latency: none, wires only.
// Backpressure: none; host_ack is a single-cycle pulse, int_clr a single-cycle strobe.
//
// Signals:
//   int_status  latched interrupt status from int_ctrl
//   int_enable  per-source enable, quasi-static
//   int_clr     one-hot, one-cycle clear strobe back to int_ctrl
//   host_ack    one-cycle acknowledge from the host for the presented vector
//   svc_req     a vector is being presented to the host
//   svc_id      index of the presented source, valid while svc_req = 1
// Modports: master = scheduler side, slave = int_ctrl / host side.
interface int_sched_if #(
   parameter int NW = 11
);
   logic [NW-1:0] int_status;
   logic [NW-1:0] int_enable;
   logic [NW-1:0] int_clr;
   logic          host_ack;
   logic          svc_req;
   logic [3:0]    svc_id;

   modport master (
      input  int_status,
      input  int_enable,
      input  host_ack,
      output svc_req,
      output svc_id,
      output int_clr
   );

   modport slave (
      output int_status,
      output int_enable,
      output host_ack,
      input  svc_req,
      input  svc_id,
      input  int_clr
   );
endinterface

// File: rtl/int_sched.sv
// Interrupt service scheduler: presents one pending source at a time to the host,
// waits for host_ack, then strobes a one-cycle clear back to int_ctrl.
// Latency: pending -> svc_req 1 cycle; host_ack -> int_clr 1 cycle; 2 HOLD cycles after each service.
// Backpressure: a source not acked within rg_ack_timeout cycles is skipped (no clear) and counted.
//
// Ports:
//   clk_32k         sole clock (32 kHz domain)
//   rst             synchronous active-high reset
//   sif             service handshake bundle (master modport)
//   rg_rr_en        0 = fixed priority (bit 0 highest), 1 = round-robin from rr_ptr
//   rg_ack_timeout  acknowledge timeout in cycles, 0 disables it
//   timeout_flag    one-cycle pulse when a timeout expires
//   miss_cnt        saturating count of timeouts
//   busy            FSM is not in IDLE
module int_sched #(
   parameter int NW = 11,
   parameter int TW = 11
) (
   input  logic          clk_32k,
   input  logic          rst,
   int_sched_if.master   sif,
   input  logic          rg_rr_en,
   input  logic [TW-1:0] rg_ack_timeout,
   output logic          timeout_flag,
   output logic [7:0]    miss_cnt,
   output logic          busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_CLEAR = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    svc_id_q, svc_id_d;
   logic [3:0]    rr_ptr_q, rr_ptr_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          hold_q, hold_d;
   logic          timeout_flag_q, timeout_flag_d;
   logic [7:0]    miss_cnt_q, miss_cnt_d;

   // Pending widened to 16 bits so any 4-bit index is in range for every NW.
   logic [15:0]   pend16;
   logic          win_vld;
   logic [3:0]    win_id;
   logic [4:0]    rr_idx;
   logic [3:0]    next_ptr;
   logic          tmo_hit;
   logic [15:0]   clr16;

   assign pend16 = 16'(sif.int_status & sif.int_enable);

   // Winner selection. Loops run high-to-low so the last hit, i.e. the lowest
   // index (fixed) or the smallest offset from rr_ptr (round-robin), wins.
   always_comb begin
      win_vld = 1'b0;
      win_id  = 4'd0;
      rr_idx  = 5'd0;
      if (!rg_rr_en) begin
         for (int i = NW - 1; i >= 0; i--) begin
            if (pend16[i]) begin
               win_vld = 1'b1;
               win_id  = 4'(i);
            end
         end
      end else begin
         for (int i = NW - 1; i >= 0; i--) begin
            rr_idx = {1'b0, rr_ptr_q} + 5'(i);
            if (rr_idx >= 5'(NW)) begin
               rr_idx = rr_idx - 5'(NW);
            end
            if (pend16[rr_idx[3:0]]) begin
               win_vld = 1'b1;
               win_id  = rr_idx[3:0];
            end
         end
      end
   end

   // Round-robin pointer moves just past the source that was last serviced or skipped.
   assign next_ptr = (svc_id_q == 4'(NW - 1)) ? 4'd0 : svc_id_q + 4'd1;

   // Timeout register is read live every WAIT cycle so a reprogram takes effect immediately.
   assign tmo_hit = (rg_ack_timeout != '0) && (tcnt_q == rg_ack_timeout - TW'(1));

   always_comb begin
      state_d        = state_q;
      svc_id_d       = svc_id_q;
      rr_ptr_d       = rr_ptr_q;
      tcnt_d         = tcnt_q;
      hold_d         = hold_q;
      timeout_flag_d = 1'b0;
      miss_cnt_d     = miss_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (win_vld) begin
               svc_id_d = win_id;
               tcnt_d   = '0;
               state_d  = ST_WAIT;
            end
         end

         ST_WAIT: begin
            tcnt_d = (&tcnt_q) ? tcnt_q : tcnt_q + TW'(1);
            if (!pend16[svc_id_q]) begin
               // Source withdrawn or cleared elsewhere: drop it quietly.
               state_d = ST_IDLE;
            end else if (sif.host_ack) begin
               // Ack wins over a timeout expiring in the same cycle.
               state_d = ST_CLEAR;
            end else if (tmo_hit) begin
               timeout_flag_d = 1'b1;
               miss_cnt_d     = (&miss_cnt_q) ? miss_cnt_q : miss_cnt_q + 8'd1;
               rr_ptr_d       = next_ptr;
               hold_d         = 1'b0;
               state_d        = ST_HOLD;
            end
         end

         ST_CLEAR: begin
            rr_ptr_d = next_ptr;
            hold_d   = 1'b0;
            state_d  = ST_HOLD;
         end

         ST_HOLD: begin
            // Two cycles so int_ctrl registers the clear before pending is looked at again.
            if (hold_q) begin
               state_d = ST_IDLE;
            end else begin
               hold_d = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_32k) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         svc_id_q       <= 4'd0;
         rr_ptr_q       <= 4'd0;
         tcnt_q         <= '0;
         hold_q         <= 1'b0;
         timeout_flag_q <= 1'b0;
         miss_cnt_q     <= 8'd0;
      end else begin
         state_q        <= state_d;
         svc_id_q       <= svc_id_d;
         rr_ptr_q       <= rr_ptr_d;
         tcnt_q         <= tcnt_d;
         hold_q         <= hold_d;
         timeout_flag_q <= timeout_flag_d;
         miss_cnt_q     <= miss_cnt_d;
      end
   end

   // Clear strobe is decoded from the registered state, so a reset that keeps
   // the FSM out of CLEAR also guarantees no strobe.
   assign clr16        = {15'd0, (state_q == ST_CLEAR)} << svc_id_q;
   assign sif.int_clr  = clr16[NW-1:0];
   assign sif.svc_req  = (state_q == ST_WAIT);
   assign sif.svc_id   = svc_id_q;
   assign timeout_flag = timeout_flag_q;
   assign miss_cnt     = miss_cnt_q;
   assign busy         = (state_q != ST_IDLE);

endmodule
